// File: rtl/rs422_tx.sv
// rs422_tx: 4-deep FIFO feeding an 8-bit serial framer paced by rising edges of an external baud clock.
module rs422_tx #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk1_8m,
  input  logic       rst,
  input  logic       clk_baud,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic [2:0] fifo_level
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic STOP_LAST = STOP_BITS == 2;
  state_t state_q, state_d;
  logic clk_baud_q, tick, push, pop;
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d, bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic stop_cnt_q, stop_cnt_d, txd_q, txd_d;
  assign tick = clk_baud & ~clk_baud_q;
  assign tx_ready = count_q < 3'd4;
  assign push = tx_valid & tx_ready;
  assign count_d = count_q + {2'b0, push} - {2'b0, pop};
  assign fifo_level = count_q;
  assign txd = txd_q;
  assign busy = state_q != IDLE || count_q != 3'd0;
  // The shift register rotates so its XOR still equals the byte's parity after bit 7.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d = txd_q;
    pop = 1'b0;
    if (tick)
      case (state_q)
        IDLE:
          if (count_q != 3'd0) begin
            pop = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d = 1'b0;
            state_d = START;
          end
        START: begin
          txd_d = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d = DATA;
        end
        DATA:
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
            txd_d = PARITY_EN ? (^shift_q ^ PARITY_ODD) : 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            shift_d = {shift_q[0], shift_q[7:1]};
            txd_d = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        PARITY: begin
          txd_d = 1'b1;
          stop_cnt_d = 1'b0;
          state_d = STOP;
        end
        STOP:
          if (stop_cnt_q != STOP_LAST) stop_cnt_d = 1'b1;
          else if (count_q != 3'd0) begin
            pop = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d = 1'b0;
            state_d = START;
          end else begin
            txd_d = 1'b1;
            state_d = IDLE;
          end
        default: state_d = IDLE;
      endcase
  end
  // Baud edge detector starts high so a baud line already high at release is not a tick.
  always_ff @(posedge clk1_8m or posedge rst)
    if (rst) begin
      clk_baud_q <= 1'b1;
      state_q <= IDLE;
      shift_q <= 8'h00;
      bit_cnt_q <= 3'd0;
      stop_cnt_q <= 1'b0;
      txd_q <= 1'b1;
      count_q <= 3'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      mem_q <= '{default: 8'h00};
    end else begin
      clk_baud_q <= clk_baud;
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q <= txd_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= tx_data;
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
    end
endmodule

// File: tb/tb_rs422_tx.sv
// tb_rs422_tx: scoreboard bench driving three rs422_tx framings from one shared baud clock.
module tb_rs422_tx;
  localparam int H = 4;
  logic clk = 0, rst = 0, clk_baud = 0, baud_en = 0, mon_en = 0;
  logic [2:0] tv = 3'b000, tr, txd, busy;
  logic [7:0] td [3];
  logic [2:0] lvl [3];
  int errors = 0, checks = 0;
  bit q0[$], q1[$], q2[$];
  int bitpos [3] = '{0, 0, 0};
  int pe [3] = '{0, 1, 1};
  int odd [3] = '{0, 0, 1};
  int sb [3] = '{1, 2, 1};

  rs422_tx u0 (.clk1_8m(clk), .rst(rst), .clk_baud(clk_baud), .tx_data(td[0]), .tx_valid(tv[0]),
    .tx_ready(tr[0]), .txd(txd[0]), .busy(busy[0]), .fifo_level(lvl[0]));
  rs422_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u1 (.clk1_8m(clk), .rst(rst),
    .clk_baud(clk_baud), .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(tr[1]), .txd(txd[1]),
    .busy(busy[1]), .fifo_level(lvl[1]));
  rs422_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (.clk1_8m(clk), .rst(rst),
    .clk_baud(clk_baud), .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(tr[2]), .txd(txd[2]),
    .busy(busy[2]), .fifo_level(lvl[2]));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int flen(int i);
    return 9 + pe[i] + sb[i];
  endfunction

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic bit qpop(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Line image of one byte: start, data LSB first, optional parity, stop bits.
  function automatic void push_frame(int i, logic [7:0] d);
    bit f[$];
    f.push_back(1'b0);
    for (int b = 0; b < 8; b++) f.push_back(d[b]);
    if (pe[i] != 0) f.push_back((^d) ^ (odd[i] != 0));
    for (int s = 0; s < sb[i]; s++) f.push_back(1'b1);
    foreach (f[k])
      case (i)
        0: q0.push_back(f[k]);
        1: q1.push_back(f[k]);
        default: q2.push_back(f[k]);
      endcase
  endfunction

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (baud_en) begin
        c++;
        if (c == H) begin
          c = 0;
          clk_baud = ~clk_baud;
        end
      end
    end
  end

  // Monitor: sample each line mid baud period and pop the expected bit.
  initial begin
    bit en;
    forever begin
      @(posedge clk_baud);
      en = mon_en;
      repeat (H) @(negedge clk);
      if (en && mon_en)
        for (int i = 0; i < 3; i++)
          if (bitpos[i] != 0 || txd[i] == 1'b0) begin
            checks++;
            if (qsize(i) == 0) begin
              errors++;
              $display("FAIL dut%0d_unexpected_frame: got txd=%0b expected idle 1", i, txd[i]);
            end else begin
              checks--;
              chk($sformatf("dut%0d_bit%0d", i, bitpos[i]), txd[i], qpop(i));
              bitpos[i] = (bitpos[i] + 1) % flen(i);
            end
          end
    end
  end

  task automatic step(logic [2:0] v, logic [7:0] a, logic [7:0] b, logic [7:0] d);
    @(negedge clk);
    tv = v;
    td[0] = a;
    td[1] = b;
    td[2] = d;
    for (int i = 0; i < 3; i++) if (tv[i] && tr[i]) push_frame(i, td[i]);
  endtask

  task automatic baud_hold(logic v);
    baud_en = 1;
    for (int k = 0; k < 4 * H && clk_baud !== v; k++) @(posedge clk);
    baud_en = 0;
  endtask

  task automatic drain(string tag);
    bit done;
    done = 0;
    for (int k = 0; k < 8000 && !done; k++) begin
      @(negedge clk);
      done = qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0 &&
             bitpos[0] == 0 && bitpos[1] == 0 && bitpos[2] == 0;
    end
    chk({tag, "_drained"}, done, 1);
    repeat (4 * H) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_txd_idle%0d", tag, i), txd[i], 1);
      chk($sformatf("%s_busy%0d", tag, i), busy[i], 0);
      chk($sformatf("%s_level%0d", tag, i), lvl[i], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    td[0] = 8'h00;
    td[1] = 8'h00;
    td[2] = 8'h00;
    #2 rst = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_txd%0d", i), txd[i], 1);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_level%0d", i), lvl[i], 0);
      chk($sformatf("rst_ready%0d", i), tr[i], 1);
    end
    repeat (3) @(negedge clk);
    rst = 0;
    // Directed frames with the baud clock parked, then released.
    step(3'b111, 8'h55, 8'h07, 8'h07);
    step(3'b000, 8'h00, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("park_level%0d", i), lvl[i], 1);
      chk($sformatf("park_busy%0d", i), busy[i], 1);
      chk($sformatf("park_txd%0d", i), txd[i], 1);
    end
    mon_en = 1;
    baud_en = 1;
    drain("directed");
    // Random traffic with high offered load so full-FIFO pushes collide with pops.
    for (int n = 0; n < 400; n++) begin
      step({3{1'b0}} | {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0},
           8'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rand_ready%0d", i), tr[i], lvl[i] < 3'd4);
        if (lvl[i] != 3'd0) chk($sformatf("rand_busy%0d", i), busy[i], 1);
      end
    end
    step(3'b000, 8'h00, 8'h00, 8'h00);
    drain("random");
    // Five writes with the baud clock stopped: the fifth must be dropped.
    baud_en = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("fill_level_w%0d", j), lvl[0], j);
      chk($sformatf("fill_ready_w%0d", j), tr[0], j < 4);
      tv = 3'b001;
      td[0] = 8'(8'h30 + j);
      if (j < 4) push_frame(0, td[0]);
    end
    @(negedge clk);
    tv = 3'b000;
    chk("full_level", lvl[0], 4);
    chk("full_ready", tr[0], 0);
    baud_en = 1;
    repeat (40) @(posedge clk_baud);
    repeat (H + 2) @(negedge clk);
    chk("back_to_back_left", qsize(0), 0);
    drain("burst");
    // Reset in the middle of data bit 3 with bytes still queued.
    step(3'b001, 8'hA5, 8'h00, 8'h00);
    step(3'b001, 8'h3C, 8'h00, 8'h00);
    step(3'b001, 8'h81, 8'h00, 8'h00);
    step(3'b000, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 2000 && bitpos[0] != 5; k++) @(negedge clk);
    chk("reached_bit3", bitpos[0], 5);
    chk("pre_rst_level", lvl[0], 2);
    mon_en = 0;
    #2 rst = 1;
    #1;
    chk("abort_txd", txd[0], 1);
    chk("abort_level", lvl[0], 0);
    chk("abort_ready", tr[0], 1);
    chk("abort_busy", busy[0], 0);
    baud_hold(1'b1);
    repeat (H + 2) @(negedge clk);
    q0.delete();
    q1.delete();
    q2.delete();
    bitpos = '{0, 0, 0};
    rst = 0;
    step(3'b001, 8'hC3, 8'h00, 8'h00);
    step(3'b000, 8'h00, 8'h00, 8'h00);
    repeat (6) @(negedge clk);
    chk("post_rst_txd", txd[0], 1);
    chk("post_rst_level", lvl[0], 1);
    chk("post_rst_busy", busy[0], 1);
    mon_en = 1;
    baud_en = 1;
    drain("after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
